// File: rtl/wb_mem_responder.sv
// Wishbone-style 128-bit memory responder with byte enables and configurable wait states.
// Latency: ack/err asserted 1+WAIT_CYCLES cycles after the request is sampled, one cycle wide.
// Backpressure: one transfer in flight; requests are ignored until the FSM returns to IDLE.
module wb_mem_responder #(
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [31:0] BASE_ADR    = 32'h0000_0000
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic [31:0]   i_wb_adr,
   input  logic [15:0]   i_wb_sel,
   input  logic          i_wb_we,
   input  logic [127:0]  i_wb_dat,
   input  logic          i_wb_cyc,
   input  logic          i_wb_stb,
   output logic [127:0]  o_wb_dat,
   output logic          o_wb_ack,
   output logic          o_wb_err,
   output logic          o_busy,
   output logic [15:0]   o_rd_count,
   output logic [15:0]   o_wr_count
);

   localparam int unsigned IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // One past the last valid byte address; 33 bits so the top of the map cannot wrap.
   localparam logic [32:0] LIMIT = {1'b0, BASE_ADR} + (33'(DEPTH) << 4);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state;
   state_t          next_state;
   logic [3:0]      wcnt;
   logic [3:0]      next_wcnt;
   logic            fin;

   logic [127:0]    mem [DEPTH];

   // Request attributes captured in IDLE for use at the end of the wait period.
   logic [IW-1:0]   lat_idx;
   logic            lat_ok;
   logic            lat_we;
   logic [15:0]     lat_sel;
   logic [127:0]    lat_dat;

   logic            req;
   logic [31:0]     in_off;
   logic            in_ok;
   logic [IW-1:0]   in_idx;

   logic [IW-1:0]   cur_idx;
   logic            cur_ok;
   logic            cur_we;
   logic [15:0]     cur_sel;
   logic [127:0]    cur_dat;
   logic            commit;

   assign req    = i_wb_cyc & i_wb_stb;
   assign in_off = i_wb_adr - BASE_ADR;
   assign in_ok  = (i_wb_adr >= BASE_ADR) && ({1'b0, i_wb_adr} < LIMIT);
   assign in_idx = IW'(in_off >> 4);

   // With no wait states the transfer completes on the sampling edge, so the live
   // bus values are used directly; otherwise the captured copy is used.
   assign cur_idx = (state == IDLE) ? in_idx   : lat_idx;
   assign cur_ok  = (state == IDLE) ? in_ok    : lat_ok;
   assign cur_we  = (state == IDLE) ? i_wb_we  : lat_we;
   assign cur_sel = (state == IDLE) ? i_wb_sel : lat_sel;
   assign cur_dat = (state == IDLE) ? i_wb_dat : lat_dat;
   assign commit  = fin & cur_ok;

   assign o_busy = (state != IDLE) & ~(o_wb_ack | o_wb_err);

   // Next-state logic: capture, count down wait states, abort on cyc drop, single RESP cycle.
   always_comb begin
      next_state = state;
      next_wcnt  = wcnt;
      fin        = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               if (WAIT_CYCLES > 0) begin
                  next_state = WAIT;
                  next_wcnt  = 4'(WAIT_CYCLES - 1);
               end else begin
                  next_state = RESP;
                  fin        = 1'b1;
               end
            end
         end
         WAIT: begin
            if (!i_wb_cyc) begin
               next_state = IDLE;
               next_wcnt  = 4'd0;
            end else if (wcnt == 4'd0) begin
               next_state = RESP;
               fin        = 1'b1;
            end else begin
               next_wcnt = wcnt - 4'd1;
            end
         end
         RESP: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
            next_wcnt  = 4'd0;
         end
      endcase
   end

   // Control state: FSM, wait counter, response strobes and saturating counters.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         wcnt       <= 4'd0;
         o_wb_ack   <= 1'b0;
         o_wb_err   <= 1'b0;
         o_rd_count <= 16'd0;
         o_wr_count <= 16'd0;
      end else begin
         state    <= next_state;
         wcnt     <= next_wcnt;
         o_wb_ack <= fin & cur_ok;
         o_wb_err <= fin & ~cur_ok;
         if (commit && cur_we && (o_wr_count != 16'hFFFF)) begin
            o_wr_count <= o_wr_count + 16'd1;
         end
         if (commit && !cur_we && (o_rd_count != 16'hFFFF)) begin
            o_rd_count <= o_rd_count + 16'd1;
         end
      end
   end

   // Datapath: request capture, byte-masked memory write, read data register.
   // Memory is deliberately left out of the reset branch so contents survive reset,
   // while the reset term still blocks any write during reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_wb_dat <= 128'd0;
         lat_idx  <= '0;
         lat_ok   <= 1'b0;
         lat_we   <= 1'b0;
         lat_sel  <= 16'd0;
         lat_dat  <= 128'd0;
      end else begin
         if ((state == IDLE) && req) begin
            lat_idx <= in_idx;
            lat_ok  <= in_ok;
            lat_we  <= i_wb_we;
            lat_sel <= i_wb_sel;
            lat_dat <= i_wb_dat;
         end
         if (commit && cur_we) begin
            for (int b = 0; b < 16; b++) begin
               if (cur_sel[b]) begin
                  mem[cur_idx][8*b +: 8] <= cur_dat[8*b +: 8];
               end
            end
         end
         if (commit && !cur_we) begin
            o_wb_dat <= mem[cur_idx];
         end
      end
   end

endmodule

// File: tb/tb_wb_mem_responder.sv
// Directed bench for wb_mem_responder with WAIT_CYCLES=2, DEPTH=256, BASE_ADR=0.
// Checks reset, latency, byte enables, range errors, abort, stb-only drop and async reset.
// Inputs driven 1ns after posedge; outputs sampled on negedge.
module tb_wb_mem_responder;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [31:0]   adr = 32'd0;
   logic [15:0]   sel = 16'd0;
   logic          we = 1'b0;
   logic [127:0]  wdat = 128'd0;
   logic          cyc = 1'b0;
   logic          stb = 1'b0;
   logic [127:0]  rdat;
   logic          ack;
   logic          err;
   logic          busy;
   logic [15:0]   rd_count;
   logic [15:0]   wr_count;

   int checks = 0;
   int failures = 0;

   localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
   localparam logic [127:0] V4 = 128'h0123456789ABCDEF01234567FFFFFFFF;
   localparam logic [127:0] D2 = 128'hDEADBEEFCAFEF00D123456789ABCDEF0;

   wb_mem_responder #(
      .DEPTH(256),
      .WAIT_CYCLES(2),
      .BASE_ADR(32'h0000_0000)
   ) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .i_wb_adr(adr),
      .i_wb_sel(sel),
      .i_wb_we(we),
      .i_wb_dat(wdat),
      .i_wb_cyc(cyc),
      .i_wb_stb(stb),
      .o_wb_dat(rdat),
      .o_wb_ack(ack),
      .o_wb_err(err),
      .o_busy(busy),
      .o_rd_count(rd_count),
      .o_wr_count(wr_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Full transfer: returns once the response cycle and the following cycle are checked.
   task automatic xfer(input string tag, input logic w, input logic [31:0] a,
                       input logic [15:0] s, input logic [127:0] d, input logic exp_err);
      int lat;
      bit seen;
      @(posedge clk);
      #1;
      adr = a; sel = s; we = w; wdat = d; cyc = 1'b1; stb = 1'b1;
      @(posedge clk);
      lat = 0;
      seen = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         if (!seen) begin
            @(negedge clk);
            if (ack || err) begin
               seen = 1'b1;
               lat = k;
            end
         end
      end
      check({tag, "_latency"}, 128'(lat), 128'd3);
      check({tag, "_ack"}, 128'(ack), 128'(!exp_err));
      check({tag, "_err"}, 128'(err), 128'(exp_err));
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(negedge clk);
      check({tag, "_resp_width"}, 128'({ack, err}), 128'd0);
   endtask

   initial begin
      // Async reset assertion without any clock edge.
      #1 rst_n = 1'b0;
      #1;
      check("reset_ack", 128'(ack), 128'd0);
      check("reset_err", 128'(err), 128'd0);
      check("reset_busy", 128'(busy), 128'd0);
      check("reset_dat", rdat, 128'd0);
      check("reset_counts", 128'({rd_count, wr_count}), 128'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Full-word write, then read back.
      xfer("wr_full", 1'b1, 32'h10, 16'hFFFF, D1, 1'b0);
      check("wr_full_wrcnt", 128'(wr_count), 128'd1);
      xfer("rd_full", 1'b0, 32'h10, 16'h0000, 128'd0, 1'b0);
      check("rd_full_dat", rdat, D1);
      check("rd_full_rdcnt", 128'(rd_count), 128'd1);

      // Low-dword byte-enable write.
      xfer("wr_part", 1'b1, 32'h10, 16'h000F, {128{1'b1}}, 1'b0);
      xfer("rd_part", 1'b0, 32'h1C, 16'h0000, 128'd0, 1'b0);
      check("rd_part_dat", rdat, V4);
      check("rd_part_counts", 128'({rd_count, wr_count}), 128'({16'd2, 16'd2}));

      // First out-of-range address.
      xfer("rd_oor", 1'b0, 32'h1000, 16'hFFFF, 128'd0, 1'b1);
      check("rd_oor_dat", rdat, V4);
      check("rd_oor_counts", 128'({rd_count, wr_count}), 128'({16'd2, 16'd2}));

      // Abort: cyc dropped one cycle after the write request.
      @(posedge clk);
      #1;
      adr = 32'h10; sel = 16'hFFFF; we = 1'b1; wdat = 128'd0; cyc = 1'b1; stb = 1'b1;
      @(posedge clk);
      #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      begin
         bit any_resp;
         any_resp = 1'b0;
         for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ack || err) any_resp = 1'b1;
         end
         check("abort_no_resp", 128'(any_resp), 128'd0);
      end
      check("abort_idle", 128'(busy), 128'd0);
      xfer("rd_after_abort", 1'b0, 32'h10, 16'h0000, 128'd0, 1'b0);
      check("abort_mem", rdat, V4);
      check("abort_counts", 128'({rd_count, wr_count}), 128'({16'd3, 16'd2}));

      // sel = 0 write is acknowledged and counted but changes nothing.
      xfer("wr_sel0", 1'b1, 32'h10, 16'h0000, 128'd0, 1'b0);
      xfer("rd_sel0", 1'b0, 32'h10, 16'h0000, 128'd0, 1'b0);
      check("sel0_mem", rdat, V4);
      check("sel0_counts", 128'({rd_count, wr_count}), 128'({16'd4, 16'd3}));

      // Last in-range word; stb dropped after acceptance must not abort.
      @(posedge clk);
      #1;
      adr = 32'hFF0; sel = 16'hFFFF; we = 1'b1; wdat = D2; cyc = 1'b1; stb = 1'b1;
      @(posedge clk);
      #1;
      stb = 1'b0;
      begin
         int lat;
         lat = 0;
         for (int k = 1; k <= 10; k++) begin
            if (lat == 0) begin
               @(negedge clk);
               if (ack) lat = k;
            end
         end
         check("stb_drop_latency", 128'(lat), 128'd3);
      end
      cyc = 1'b0; we = 1'b0;
      xfer("rd_last", 1'b0, 32'hFF0, 16'h0000, 128'd0, 1'b0);
      check("rd_last_dat", rdat, D2);

      // Async reset during the wait period of a write.
      @(posedge clk);
      #1;
      adr = 32'h10; sel = 16'hFFFF; we = 1'b1; wdat = 128'd0; cyc = 1'b1; stb = 1'b1;
      @(posedge clk);
      #1;
      check("mid_busy", 128'(busy), 128'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_reset_outs", 128'({ack, err, busy}), 128'd0);
      check("mid_reset_dat", rdat, 128'd0);
      check("mid_reset_counts", 128'({rd_count, wr_count}), 128'd0);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      xfer("rd_after_reset", 1'b0, 32'h10, 16'h0000, 128'd0, 1'b0);
      check("reset_mem_kept", rdat, V4);
      check("reset_counts_after", 128'({rd_count, wr_count}), 128'({16'd1, 16'd0}));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time limit so the run always terminates.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/wb_mem_responder.md
WB_MEM_RESPONDER -- requirements
Module: wb_mem_responder

Interface
- REQ-001: Parameter DEPTH, default 256, number of 128-bit memory words.
- REQ-002: Parameter WAIT_CYCLES, default 2, wait states inserted before each acknowledge; range 0-15.
- REQ-003: Parameter BASE_ADR, default 32'h0000_0000, byte address of word 0; 16-byte aligned.
- REQ-004: i_clk  in  1  sole clock; all state changes on rising edge.
- REQ-005: i_rst_n  in  1  asynchronous active-low reset.
- REQ-006: i_wb_adr  in  32  byte address from core; bits [3:0] ignored.
- REQ-007: i_wb_sel  in  16  byte enables; bit n selects data bits [8n+7:8n].
- REQ-008: i_wb_we  in  1  1 = write, 0 = read.
- REQ-009: i_wb_dat  in  128  write data from core.
- REQ-010: i_wb_cyc  in  1  bus cycle active.
- REQ-011: i_wb_stb  in  1  transfer strobe.
- REQ-012: o_wb_dat  out  128  registered read data.
- REQ-013: o_wb_ack  out  1  single-cycle successful-transfer acknowledge.
- REQ-014: o_wb_err  out  1  single-cycle error acknowledge.
- REQ-015: o_busy  out  1  high while a transfer is accepted and not yet acknowledged.
- REQ-016: o_rd_count / o_wr_count  out  16 each  saturating counts of acked reads / writes.

Function
- REQ-017: FSM states IDLE, WAIT, RESP; a request is i_wb_cyc & i_wb_stb.
- REQ-018: In IDLE, a request latches address, we, sel and write data; next state WAIT if WAIT_CYCLES > 0 (counter loaded with WAIT_CYCLES-1), else RESP.
- REQ-019: WAIT decrements the counter each cycle; counter 0 -> RESP.
- REQ-020: Latency: ack/err high exactly 1+WAIT_CYCLES cycles after the edge sampling the request; high for exactly one cycle (RESP); RESP -> IDLE unconditionally.
- REQ-021: A request held through RESP is not re-accepted in RESP; it is re-sampled as new in IDLE, giving a minimum of 2 cycles per transfer at WAIT_CYCLES = 0.
- REQ-022: Word index = (adr - BASE_ADR) >> 4; address in range iff BASE_ADR <= adr < BASE_ADR + 16*DEPTH.
- REQ-023: In range, on the edge entering RESP: write updates only bytes with sel = 1 (sel = 0 is a legal no-op write that is still acked); read loads o_wb_dat with the full word regardless of sel.
- REQ-024: Out of range: o_wb_err instead of o_wb_ack, no memory change, o_wb_dat unchanged, no counter change.
- REQ-025: o_wb_ack and o_wb_err are never high together.
- REQ-026: o_wb_dat holds its value until the next in-range read.
- REQ-027: i_wb_cyc low in WAIT aborts: return to IDLE, no write, no ack/err, no count; i_wb_stb low alone does not abort.
- REQ-028: Counters increment on ack cycles only; saturate at 16'hFFFF.
- REQ-029: o_busy = (state != IDLE) & !(o_wb_ack | o_wb_err).

Reset
- REQ-030: i_rst_n low forces immediately: state IDLE, o_wb_ack 0, o_wb_err 0, o_busy 0, o_wb_dat 0, counters 0, wait counter 0.
- REQ-031: Memory contents are not reset; reset mid-transfer discards the transfer with no write.
- REQ-032: First request is sampled on the first rising edge with i_rst_n high.

Verification
- REQ-033: WAIT_CYCLES=2, write adr 0x10, sel 16'hFFFF, dat 128'h0123...CDEF -> ack on 3rd cycle after request, one cycle wide; o_wr_count=1.
- REQ-034: Read adr 0x10 after above -> o_wb_dat = 128'h0123...CDEF with ack; o_rd_count=1.
- REQ-035: Write sel 16'h000F dat all-ones to word 0x10, then read -> only bits [31:0] = 32'hFFFFFFFF, upper 96 bits unchanged.
- REQ-036: Read adr BASE_ADR+16*DEPTH (0x1000) -> o_wb_err one cycle, o_wb_ack 0, counters unchanged.
- REQ-037: Drop i_wb_cyc one cycle after write request (WAIT_CYCLES=2) -> no ack, memory unchanged, FSM IDLE.
- REQ-038: Assert i_rst_n=0 asynchronously during WAIT of a write -> outputs zero without a clock edge; memory word unchanged after release.
